// File: rtl/adc_spi_resp.sv
// SPI-mode-0 responder emulating an 8-channel ADC: a 16-bit command selects a
// channel, and the following frame shifts back that channel's 12-bit value.
module adc_spi_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic        wr_en,
    input  logic [2:0]  wr_chnnl,
    input  logic [11:0] wr_data,
    output logic        cnv_done,
    output logic [2:0]  cnv_chnnl,
    output logic        frame_err,
    output logic [7:0]  txn_cnt
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_q, state_d;

    logic        ss_meta, ss_sync, ss_prev;
    logic        sclk_meta, sclk_sync, sclk_prev;
    logic        mosi_meta, mosi_sync;
    logic [1:0]  settle;
    logic        armed;

    logic [4:0]  bit_cnt;
    logic [15:0] rx_shift;
    logic [15:0] tx_shift;
    logic [11:0] result;
    logic [11:0] chan_tbl [8];

    logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic        start, do_rx, do_tx, accept, reject;
    logic [2:0]  cap_ch;

    // Falls only count once the synchronizer has seen a real high after reset,
    // so a frame already running at reset release is ignored.
    assign ss_fall   = armed & ss_prev & ~ss_sync;
    assign ss_rise   = ~ss_prev & ss_sync;
    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign sclk_fall = ~sclk_sync & sclk_prev;
    assign cap_ch    = rx_shift[13:11];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        do_rx   = 1'b0;
        do_tx   = 1'b0;
        accept  = 1'b0;
        reject  = 1'b0;
        MISO    = 1'b1;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                MISO = tx_shift[15];
                if (ss_rise) begin
                    state_d = IDLE;
                    if (bit_cnt == 5'd16 && rx_shift[15:14] == 2'b00) accept = 1'b1;
                    else                                              reject = 1'b1;
                end else begin
                    do_rx = sclk_rise;
                    do_tx = sclk_fall;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            ss_prev   <= 1'b1;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            settle    <= '0;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            result    <= '0;
            cnv_chnnl <= '0;
            txn_cnt   <= '0;
            cnv_done  <= 1'b0;
            frame_err <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) chan_tbl[i] <= '0;
        end else begin
            ss_meta   <= SS_n;
            ss_sync   <= ss_meta;
            ss_prev   <= ss_sync;
            sclk_meta <= SCLK;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            mosi_meta <= MOSI;
            mosi_sync <= mosi_meta;
            settle    <= {settle[0], 1'b1};
            if (settle[1] && ss_sync) armed <= 1'b1;

            cnv_done  <= accept;
            frame_err <= reject;

            if (wr_en) chan_tbl[wr_chnnl] <= wr_data;

            if (start) begin
                bit_cnt  <= '0;
                tx_shift <= {4'b0000, result};
            end
            if (do_rx) begin
                rx_shift <= {rx_shift[14:0], mosi_sync};
                if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
            end
            if (do_tx) tx_shift <= {tx_shift[14:0], 1'b0};

            // A same-cycle host write to the captured entry bypasses the table.
            if (accept) begin
                result    <= (wr_en && wr_chnnl == cap_ch) ? wr_data : chan_tbl[cap_ch];
                cnv_chnnl <= cap_ch;
                txn_cnt   <= txn_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_resp.sv
// Self-checking bench for adc_spi_resp: SPI initiator model, reference table
// model and a scoreboard of expected accept/reject events.
module tb_adc_spi_resp;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n, SCLK, MOSI, MISO;
    logic        wr_en;
    logic [2:0]  wr_chnnl;
    logic [11:0] wr_data;
    logic        cnv_done, frame_err;
    logic [2:0]  cnv_chnnl;
    logic [7:0]  txn_cnt;

    adc_spi_resp dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .wr_en    (wr_en),
        .wr_chnnl (wr_chnnl),
        .wr_data  (wr_data),
        .cnv_done (cnv_done),
        .cnv_chnnl(cnv_chnnl),
        .frame_err(frame_err),
        .txn_cnt  (txn_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [2:0] ch;
        logic [7:0] cnt;
    } evt_t;

    evt_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done   = 0;

    logic [11:0] m_tbl [8];
    logic [11:0] m_result;
    logic [7:0]  m_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_tbl[i] = '0;
        m_result = '0;
        m_cnt    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        model_reset();
        wait_clks(3);
    endtask

    task automatic host_write(input logic [2:0] ch, input logic [11:0] d);
        wr_en    = 1'b1;
        wr_chnnl = ch;
        wr_data  = d;
        wait_clks(1);
        wr_en    = 1'b0;
        m_tbl[ch] = d;
    endtask

    task automatic spi_frame(input logic [15:0] cmd, input int nbits, input bit do_wr,
                             input logic [2:0] wch, input logic [11:0] wdat);
        logic [15:0] miso_got;
        logic [15:0] miso_exp;
        logic [2:0]  ch;
        evt_t        e;
        miso_exp = {4'b0000, m_result};
        miso_got = '0;
        ch       = cmd[13:11];
        if (nbits == 16 && cmd[15:14] == 2'b00) begin
            m_result = (do_wr && wch == ch) ? wdat : m_tbl[ch];
            m_cnt    = m_cnt + 8'd1;
            e.is_err = 1'b0;
            e.ch     = ch;
            e.cnt    = m_cnt;
        end else begin
            e.is_err = 1'b1;
            e.ch     = '0;
            e.cnt    = '0;
        end
        if (do_wr) m_tbl[wch] = wdat;
        exp_q.push_back(e);

        SS_n = 1'b0;
        wait_clks(6);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? cmd[15 - i] : 1'b0;
            wait_clks(HALF);
            if (i < 16) miso_got[15 - i] = MISO;
            SCLK = 1'b1;
            wait_clks(HALF);
            SCLK = 1'b0;
        end
        wait_clks(6);
        SS_n = 1'b1;
        if (do_wr) begin
            // raw rise -> two sync stages -> evaluation on the third edge
            wait_clks(2);
            wr_en    = 1'b1;
            wr_chnnl = wch;
            wr_data  = wdat;
            wait_clks(1);
            wr_en    = 1'b0;
        end
        wait_clks(6);
        if (nbits == 16) check_val("frame_miso", miso_got, miso_exp);
    endtask

    always @(negedge clk) begin
        if (!rst && (cnv_done || frame_err)) begin
            evt_t e;
            if (cnv_done) n_done++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_evt", {cnv_done, frame_err}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check_val("evt_kind", {cnv_done, frame_err}, e.is_err ? 2'b01 : 2'b10);
                if (!e.is_err) begin
                    check_val("cnv_chnnl", cnv_chnnl, e.ch);
                    check_val("txn_cnt_evt", txn_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        int done_before;
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        wr_en = 1'b0; wr_chnnl = '0; wr_data = '0;
        model_reset();
        wait_clks(1);
        do_reset();

        check_val("rst_miso", MISO, 1'b1);
        check_val("rst_txn_cnt", txn_cnt, 8'd0);
        check_val("rst_cnv_chnnl", cnv_chnnl, 3'd0);
        check_val("rst_pulses", {cnv_done, frame_err}, 2'b00);

        // command/read pair on channel 3
        host_write(3'd3, 12'hA5C);
        done_before = n_done;
        spi_frame(16'h1800, 16, 1'b0, '0, '0);
        spi_frame(16'h0000, 16, 1'b0, '0, '0);
        check_val("txn_cnt_two", txn_cnt, 8'd2);
        check_val("done_two", n_done - done_before, 2);

        // short and long frames, then a bad command header
        spi_frame(16'h1000, 15, 1'b0, '0, '0);
        spi_frame(16'h1000, 17, 1'b0, '0, '0);
        spi_frame(16'hC000, 16, 1'b0, '0, '0);
        check_val("txn_cnt_after_err", txn_cnt, 8'd2);
        spi_frame(16'h1800, 16, 1'b0, '0, '0);

        // write-through in the accept cycle
        host_write(3'd5, 12'h777);
        spi_frame(16'h2800, 16, 1'b1, 3'd5, 12'h123);
        spi_frame(16'h0000, 16, 1'b0, '0, '0);

        // SCLK/MOSI activity with SS_n high
        for (int i = 0; i < 5; i++) begin
            MOSI = i[0];
            SCLK = 1'b1; wait_clks(HALF);
            check_val("idle_miso", MISO, 1'b1);
            SCLK = 1'b0; wait_clks(HALF);
        end
        MOSI = 1'b0;
        check_val("idle_txn_cnt", txn_cnt, m_cnt);

        // 256 accepted commands from reset
        do_reset();
        for (int k = 0; k < 8; k++) host_write(3'(k), 12'(k * 12'h111 + 12'h00F));
        done_before = n_done;
        for (int i = 0; i < 256; i++)
            spi_frame({2'b00, 3'(i), 11'(i * 7)}, 16, 1'b0, '0, '0);
        check_val("wrap_txn_cnt", txn_cnt, 8'd0);
        check_val("wrap_done_count", n_done - done_before, 256);

        // reset in the middle of a frame
        spi_frame(16'h1800, 16, 1'b0, '0, '0);
        done_before = n_done;
        SS_n = 1'b0;
        wait_clks(6);
        for (int i = 0; i < 8; i++) begin
            MOSI = i[0];
            wait_clks(HALF); SCLK = 1'b1;
            wait_clks(HALF); SCLK = 1'b0;
        end
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        model_reset();
        wait_clks(1);
        check_val("midrst_miso", MISO, 1'b1);
        check_val("midrst_txn_cnt", txn_cnt, 8'd0);
        check_val("midrst_cnv_chnnl", cnv_chnnl, 3'd0);
        check_val("midrst_pulses", {cnv_done, frame_err}, 2'b00);
        for (int i = 0; i < 8; i++) begin
            MOSI = ~i[0];
            wait_clks(HALF); SCLK = 1'b1;
            wait_clks(HALF); SCLK = 1'b0;
            check_val("midrst_tail_miso", MISO, 1'b1);
        end
        wait_clks(6);
        SS_n = 1'b1;
        wait_clks(10);
        check_val("midrst_no_evt", n_done - done_before, 0);
        check_val("midrst_txn_after", txn_cnt, 8'd0);
        spi_frame(16'h1800, 16, 1'b0, '0, '0);
        spi_frame(16'h0000, 16, 1'b0, '0, '0);

        wait_clks(10);
        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_resp.md
ADC_SPI_RESP -- requirements
Module: adc_spi_resp

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port SS_n, input, 1 bit: SPI select from the initiator, active low, asynchronous to clk.
REQ-004 The block SHALL have the port SCLK, input, 1 bit: SPI clock from the initiator, asynchronous to clk.
REQ-005 The block SHALL have the port MOSI, input, 1 bit: command data from the initiator.
REQ-006 The block SHALL have the port MISO, output, 1 bit: conversion result data to the initiator.
REQ-007 The block SHALL have the port wr_en, input, 1 bit: host write strobe for the channel value table.
REQ-008 The block SHALL have the port wr_chnnl, input, 3 bits: index of the table entry to write.
REQ-009 The block SHALL have the port wr_data, input, 12 bits: value to write into the table entry.
REQ-010 The block SHALL have the port cnv_done, output, 1 bit: one-cycle pulse when a valid command is accepted.
REQ-011 The block SHALL have the port cnv_chnnl, output, 3 bits: channel of the last accepted command.
REQ-012 The block SHALL have the port frame_err, output, 1 bit: one-cycle pulse when a frame is malformed or rejected.
REQ-013 The block SHALL have the port txn_cnt, output, 8 bits: count of accepted commands, wrapping.

Function
REQ-014 SS_n, SCLK and MOSI SHALL each pass through a two-flop synchronizer; all edge detection SHALL use the synchronized signals, comparing the current value against the previous value.
REQ-015 The block SHALL hold an 8 x 12-bit channel value table; when wr_en=1, entry wr_chnnl SHALL take wr_data on the next clk.
REQ-016 The state machine SHALL have exactly two states, IDLE and SHIFT.
REQ-017 In IDLE, a synchronized SS_n fall SHALL move to SHIFT, clear the 5-bit bit_cnt and load tx_shift with {4'b0000, result}; MISO SHALL present tx_shift[15] from the next cycle.
REQ-018 In SHIFT, on each synchronized SCLK rise, rx_shift SHALL shift left taking MOSI into bit 0, and bit_cnt SHALL increment, saturating at 17.
REQ-019 In SHIFT, on each synchronized SCLK fall, tx_shift SHALL shift left with 0 fill, so that MISO shows the next bit (SPI mode 0, MSB first).
REQ-020 In SHIFT, a synchronized SS_n rise SHALL return the state machine to IDLE and evaluate the frame.
  - Accept: bit_cnt==16 and rx_shift[15:14]==2'b00.
  - On accept: result <= table[rx_shift[13:11]]; cnv_chnnl <= rx_shift[13:11]; cnv_done pulses for 1 cycle; txn_cnt increments (255 wraps to 0).
  - Otherwise: frame_err pulses for 1 cycle; result, cnv_chnnl and txn_cnt are unchanged.
REQ-021 Each frame SHALL return the result of the previously accepted command, so a two-frame command/read sequence yields the addressed channel value in the second frame.
REQ-022 If wr_en writes the entry being captured in the same cycle as an accept, result SHALL take wr_data (write-through bypass).
REQ-023 When in IDLE, MISO SHALL be 1.
REQ-024 SCLK SHALL toggle in IDLE without any effect on state, counters or outputs.
REQ-025 The initiator's SCLK half-period SHALL be at least 4 clk, and SS_n setup and hold around the SCLK edges SHALL be at least 4 clk.
REQ-026 MISO SHALL update within 3 clk of a raw SCLK fall.

Reset
REQ-027 When rst=1 at a clk edge, the block SHALL enter IDLE and clear all synchronizers to SS_n=1, SCLK=0, MOSI=0.
REQ-028 The same reset SHALL clear bit_cnt, rx_shift, tx_shift, result, cnv_chnnl, txn_cnt and every table entry to 0, and set cnv_done=0, frame_err=0, MISO=1.
REQ-029 A frame already in progress at reset release SHALL be ignored until the next SS_n fall.

Verification
REQ-030 Verify: table[3]=12'hA5C, command frame MOSI=16'h1800, then second frame -> cnv_done once with cnv_chnnl=3, second frame MISO=16'h0A5C, txn_cnt=2.
REQ-031 Verify: a frame of 15 SCLKs, then separately a frame of 17 SCLKs -> frame_err pulses once each; result and txn_cnt unchanged.
REQ-032 Verify: command MOSI=16'hC000 (bits [15:14]=11) -> frame_err pulse and no cnv_done.
REQ-033 Verify: wr_en with wr_chnnl=5, wr_data=12'h123 asserted in the accept cycle of command 16'h2800 -> next frame MISO=16'h0123.
REQ-034 Verify: 256 accepted commands from reset -> txn_cnt=0 and cnv_done pulsed 256 times.
REQ-035 Verify: rst asserted after 8 SCLKs of a frame -> all outputs at reset values, MISO=1, and the remaining SCLKs of that frame have no effect.
